count_display_ctrl: RTL and testbench

COUNT_DISPLAY_CTRL -- requirements
Module: count_display_ctrl

---
 rtl/count_display_ctrl_pkg.sv | 38 +++
 rtl/seg7_decode.sv | 32 +++
 rtl/count_display_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_count_display_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/count_display_ctrl_pkg.sv
// Shared types and constants for the 3-digit count display controller:
// FSM states, seven-segment codes and the double-dabble step.
package count_display_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_SCAN = 2'd2
  } state_t;

  localparam int NUM_DIGITS = 3;
  localparam int CONV_STEPS = 8;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // One double-dabble iteration on {hundreds, tens, units, binary}: add 3 to
  // any BCD nibble >= 5, then shift the whole register left by one.
  function automatic logic [19:0] dd_step(input logic [19:0] sr);
    logic [19:0] adj;
    adj = sr;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      adj[8+4*i +: 4] = (adj[8+4*i +: 4] >= 4'd5) ? adj[8+4*i +: 4] + 4'd3
                                                   : adj[8+4*i +: 4];
    end
    return {adj[18:0], 1'b0};
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD-to-seven-segment decoder with a blanking input.
module seg7_decode
  import count_display_ctrl_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       blank,
  output logic [6:0] seg
);

  // Decode one BCD nibble; out-of-range nibbles and blanked digits go dark.
  always_comb begin
    seg = SEG_BLANK;
    if (blank) begin
      seg = SEG_BLANK;
    end else begin
      case (bcd)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/count_display_ctrl.sv
// Binary-to-BCD converter (sequential double-dabble) driving a multiplexed
// 3-digit seven-segment display with optional leading-zero suppression.
module count_display_ctrl
  import count_display_ctrl_pkg::*;
#(
  parameter int DWELL_CYCLES   = 1024,
  parameter int SUPPRESS_ZEROS = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ena,
  input  logic [7:0]  value,
  input  logic        load,
  output logic        busy,
  output logic        valid,
  output logic [11:0] bcd,
  output logic [6:0]  seg,
  output logic [2:0]  digit_en
);

  localparam logic [15:0] DWELL_LAST = 16'(DWELL_CYCLES - 1);
  localparam logic [2:0]  ITER_LAST  = 3'(CONV_STEPS - 1);
  localparam logic [1:0]  IDX_LAST   = 2'(NUM_DIGITS - 1);

  state_t      state_r, state_s;
  logic [19:0] shift_r;
  logic [19:0] step_next_s;
  logic [2:0]  iter_r;
  logic [15:0] dwell_r, dwell_s;
  logic [1:0]  idx_r, idx_s;
  logic        busy_r, valid_r;
  logic [11:0] bcd_r;
  logic [6:0]  seg_r;
  logic [2:0]  digit_en_r;

  logic        accept_s, step_s, done_s;
  logic        valid_next_s, valid_rise_s;
  logic [11:0] bcd_next_s;
  logic [3:0]  digit_s;
  logic        blank_s;
  logic [6:0]  seg_dec_s, seg_next_s;
  logic [2:0]  digit_en_next_s;

  // FSM state register; ena low freezes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else if (ena) begin
      state_r <= state_s;
    end else begin
      state_r <= state_r;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: state_s = load ? ST_CONV : ST_IDLE;
      ST_CONV: state_s = (iter_r == ITER_LAST) ? ST_SCAN : ST_CONV;
      ST_SCAN: state_s = load ? ST_CONV : ST_SCAN;
      default: state_s = ST_IDLE;
    endcase
  end

  // FSM control decode; a load during CONV is simply not looked at.
  always_comb begin
    accept_s = 1'b0;
    step_s   = 1'b0;
    done_s   = 1'b0;
    case (state_r)
      ST_IDLE, ST_SCAN: accept_s = ena & load;
      ST_CONV: begin
        step_s = ena;
        done_s = ena & (iter_r == ITER_LAST);
      end
      default: accept_s = 1'b0;
    endcase
  end

  assign step_next_s = dd_step(shift_r);

  // Working shift register and iteration counter of the converter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_r <= 20'd0;
      iter_r  <= 3'd0;
    end else if (accept_s) begin
      shift_r <= {12'd0, value};
      iter_r  <= 3'd0;
    end else if (step_s) begin
      shift_r <= step_next_s;
      iter_r  <= iter_r + 3'd1;
    end else begin
      shift_r <= shift_r;
      iter_r  <= iter_r;
    end
  end

  // The display reads the result on the same edge it is latched, so a new
  // value appears exactly when the conversion completes.
  assign bcd_next_s   = done_s ? step_next_s[19:8] : bcd_r;
  assign valid_next_s = valid_r | done_s;
  assign valid_rise_s = valid_next_s & ~valid_r;

  // Status and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r  <= 1'b0;
      valid_r <= 1'b0;
      bcd_r   <= 12'd0;
    end else if (ena) begin
      busy_r  <= (state_s == ST_CONV);
      valid_r <= valid_next_s;
      bcd_r   <= bcd_next_s;
    end else begin
      busy_r  <= busy_r;
      valid_r <= valid_r;
      bcd_r   <= bcd_r;
    end
  end

  // Dwell counter and digit index; scanning restarts at units when valid rises.
  always_comb begin
    dwell_s = dwell_r;
    idx_s   = idx_r;
    if (valid_rise_s) begin
      dwell_s = 16'd0;
      idx_s   = 2'd0;
    end else if (valid_r) begin
      if (dwell_r == DWELL_LAST) begin
        dwell_s = 16'd0;
        idx_s   = (idx_r == IDX_LAST) ? 2'd0 : idx_r + 2'd1;
      end else begin
        dwell_s = dwell_r + 16'd1;
        idx_s   = idx_r;
      end
    end else begin
      dwell_s = dwell_r;
      idx_s   = idx_r;
    end
  end

  // Scan counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dwell_r <= 16'd0;
      idx_r   <= 2'd0;
    end else if (ena) begin
      dwell_r <= dwell_s;
      idx_r   <= idx_s;
    end else begin
      dwell_r <= dwell_r;
      idx_r   <= idx_r;
    end
  end

  // Digit select and leading-zero blanking for the digit about to be shown.
  always_comb begin
    digit_s = 4'd0;
    blank_s = 1'b1;
    case (idx_s)
      2'd0: begin
        digit_s = bcd_next_s[3:0];
        blank_s = 1'b0;
      end
      2'd1: begin
        digit_s = bcd_next_s[7:4];
        blank_s = (SUPPRESS_ZEROS != 0) && (bcd_next_s[11:4] == 8'd0);
      end
      2'd2: begin
        digit_s = bcd_next_s[11:8];
        blank_s = (SUPPRESS_ZEROS != 0) && (bcd_next_s[11:8] == 4'd0);
      end
      default: begin
        digit_s = 4'd0;
        blank_s = 1'b1;
      end
    endcase
  end

  seg7_decode u_seg7_decode (
    .bcd   (digit_s),
    .blank (blank_s),
    .seg   (seg_dec_s)
  );

  assign seg_next_s      = valid_next_s ? seg_dec_s : SEG_BLANK;
  assign digit_en_next_s = valid_next_s ? 3'(3'b001 << idx_s) : 3'b000;

  // Display output registers; seg and digit_en always move together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_r      <= SEG_BLANK;
      digit_en_r <= 3'b000;
    end else if (ena) begin
      seg_r      <= seg_next_s;
      digit_en_r <= digit_en_next_s;
    end else begin
      seg_r      <= seg_r;
      digit_en_r <= digit_en_r;
    end
  end

  assign busy     = busy_r;
  assign valid    = valid_r;
  assign bcd      = bcd_r;
  assign seg      = seg_r;
  assign digit_en = digit_en_r;

endmodule

// File: tb/tb_count_display_ctrl.sv
// Scoreboard bench for count_display_ctrl: loads push expected results, a
// negedge monitor checks conversions, display contents, scan order and dwell.
module tb_count_display_ctrl;

  localparam int DW = 4;

  typedef struct {
    logic [7:0]  v;
    logic [11:0] bcd;
    logic [6:0]  su, st, sh;  // units/tens/hundreds, zero suppression on
    logic [6:0]  zt, zh;      // tens/hundreds, zero suppression off
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        ena = 1'b1;
  logic [7:0]  value = 8'd0;
  logic        load = 1'b0;
  logic        busy, valid;
  logic [11:0] bcd;
  logic [6:0]  seg;
  logic [2:0]  digit_en;
  logic        busy_nz, valid_nz;
  logic [11:0] bcd_nz;
  logic [6:0]  seg_nz;
  logic [2:0]  digit_en_nz;

  int n_tests = 0;
  int n_fail  = 0;

  exp_t exp_q[$];
  exp_t tbl[7];
  exp_t cur;
  exp_t e;
  logic       ena_seen = 1'b1;
  logic       prev_busy = 1'b0;
  logic       exp_valid = 1'b0;
  logic [2:0] prev_de = 3'b000;
  logic [2:0] next_de;
  logic [6:0] es, ez;
  int         busy_len = 0;
  int         run_len = 0;

  count_display_ctrl #(.DWELL_CYCLES(DW), .SUPPRESS_ZEROS(1)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .value(value), .load(load),
    .busy(busy), .valid(valid), .bcd(bcd), .seg(seg), .digit_en(digit_en)
  );

  count_display_ctrl #(.DWELL_CYCLES(DW), .SUPPRESS_ZEROS(0)) dut_nz (
    .clk(clk), .rst_n(rst_n), .ena(ena), .value(value), .load(load),
    .busy(busy_nz), .valid(valid_nz), .bcd(bcd_nz), .seg(seg_nz),
    .digit_en(digit_en_nz)
  );

  always #5 clk = ~clk;

  always @(posedge clk) ena_seen <= ena;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Monitor: conversion completions pop the scoreboard; display checked every cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_busy = 1'b0;
      busy_len  = 0;
      exp_valid = 1'b0;
      prev_de   = 3'b000;
      run_len   = 0;
    end else begin
      if (busy) busy_len = prev_busy ? busy_len + 1 : 1;
      if (prev_busy && !busy) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_completion", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("bcd", 32'(bcd), 32'(e.bcd));
          chk("bcd_nz", 32'(bcd_nz), 32'(e.bcd));
          chk("busy_cycles", 32'(busy_len), 32'd8);
          cur = e;
          exp_valid = 1'b1;
        end
      end
      prev_busy = busy;
      chk("valid", 32'(valid), 32'(exp_valid));
      if (exp_valid) begin
        chk("digit_onehot", 32'($onehot(digit_en)), 32'd1);
        case (digit_en)
          3'b001:  begin es = cur.su; ez = cur.su; end
          3'b010:  begin es = cur.st; ez = cur.zt; end
          3'b100:  begin es = cur.sh; ez = cur.zh; end
          default: begin es = 7'h00; ez = 7'h00; end
        endcase
        chk("seg", 32'(seg), 32'(es));
        chk("seg_nz", 32'(seg_nz), 32'(ez));
        chk("digit_en_nz", 32'(digit_en_nz), 32'(digit_en));
      end else begin
        chk("seg_blank", 32'(seg), 32'd0);
        chk("digit_en_off", 32'(digit_en), 32'd0);
      end
      if (digit_en != prev_de) begin
        next_de = (prev_de == 3'b000) ? 3'b001 : {prev_de[1:0], prev_de[2]};
        chk("digit_order", 32'(digit_en), 32'(next_de));
        if (prev_de != 3'b000) chk("dwell_len", 32'(run_len), 32'(DW));
        run_len = 1;
        prev_de = digit_en;
      end else if (ena_seen) begin
        run_len++;
      end
    end
  end

  task automatic do_load(input int idx);
    @(negedge clk);
    value = tbl[idx].v;
    load  = 1'b1;
    exp_q.push_back(tbl[idx]);
    @(negedge clk);
    load  = 1'b0;
    value = 8'h5A;
    chk("busy_on_load", 32'(busy), 32'd1);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while ((busy || exp_q.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("conv_timeout", 32'(n < 100), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    //          value   bcd      su     st     sh     zt     zh
    tbl[0] = '{8'd255, 12'h255, 7'h6D, 7'h6D, 7'h5B, 7'h6D, 7'h5B};
    tbl[1] = '{8'd7,   12'h007, 7'h07, 7'h00, 7'h00, 7'h3F, 7'h3F};
    tbl[2] = '{8'd0,   12'h000, 7'h3F, 7'h00, 7'h00, 7'h3F, 7'h3F};
    tbl[3] = '{8'd105, 12'h105, 7'h6D, 7'h3F, 7'h06, 7'h3F, 7'h06};
    tbl[4] = '{8'd9,   12'h009, 7'h6F, 7'h00, 7'h00, 7'h3F, 7'h3F};
    tbl[5] = '{8'd42,  12'h042, 7'h5B, 7'h66, 7'h00, 7'h66, 7'h3F};
    tbl[6] = '{8'd100, 12'h100, 7'h3F, 7'h3F, 7'h06, 7'h3F, 7'h06};

    #1 rst_n = 1'b0;
    #2;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_bcd", 32'(bcd), 32'd0);
    chk("rst_seg", 32'(seg), 32'd0);
    chk("rst_digit_en", 32'(digit_en), 32'd0);
    repeat (2) @(negedge clk);

    // First load accepted on the first edge after reset release; loads at N+2, N+5 ignored.
    rst_n = 1'b1;
    value = tbl[0].v;
    load  = 1'b1;
    exp_q.push_back(tbl[0]);
    @(negedge clk);
    load  = 1'b0;
    value = 8'h5A;
    chk("busy_first_load", 32'(busy), 32'd1);
    @(negedge clk); load = 1'b1; value = 8'd0;
    @(negedge clk); load = 1'b0;
    @(negedge clk);
    @(negedge clk); load = 1'b1; value = 8'd17;
    @(negedge clk); load = 1'b0;
    wait_done();
    repeat (14) @(negedge clk);

    // ena low mid-dwell freezes everything, including a load.
    ena = 1'b0;
    repeat (4) @(negedge clk);
    load = 1'b1; value = 8'd3;
    @(negedge clk);
    load = 1'b0;
    repeat (5) @(negedge clk);
    chk("busy_ena_low", 32'(busy), 32'd0);
    ena = 1'b1;
    repeat (16) @(negedge clk);

    // Reconversions from SCAN, zero suppression boundaries.
    for (int i = 1; i <= 5; i++) begin
      do_load(i);
      wait_done();
      repeat (14) @(negedge clk);
    end

    // Load 100 while showing 42: 42 stays on display until completion.
    do_load(6);
    wait_done();
    repeat (9) @(negedge clk);

    // Asynchronous reset mid-scan.
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_seg", 32'(seg), 32'd0);
    chk("async_rst_digit_en", 32'(digit_en), 32'd0);
    chk("async_rst_valid", 32'(valid), 32'd0);
    chk("async_rst_bcd", 32'(bcd), 32'd0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
